// File: rtl/tone_sequencer.sv
// tone_sequencer: fixed-priority melody ROM player driving tone/sound_en; define TONE_SEQ_MUTE_EN to add a mute input
module tone_sequencer #(
  parameter int TICK_DIV  = 5_000_000,
  parameter int GAP_TICKS = 1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [3:0] req,
`ifdef TONE_SEQ_MUTE_EN
  input  logic       mute,
`endif
  output logic [3:0] grant,
  output logic       busy,
  output logic [3:0] tone,
  output logic       sound_en
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
  state_t state, nxt;
  logic [3:0] pending, addr, addr_n, lower;
  logic [1:0] cur, pri;
  logic [2:0] dur;
  logic [TW-1:0] cnt;
  logic [7:0] nt;
  logic start, last, tick_done, note_end, gap_end;
  function automatic logic [7:0] rom(input logic [3:0] a);
    case (a)
      4'd0:    rom = 8'b0_0111_001;
      4'd1:    rom = 8'b1_0100_001;
      4'd4:    rom = 8'b0_0010_001;
      4'd5:    rom = 8'b0_0100_001;
      4'd6:    rom = 8'b0_0110_001;
      4'd7:    rom = 8'b1_0111_011;
      4'd8:    rom = 8'b0_1111_010;
      4'd9:    rom = 8'b0_1101_010;
      4'd10:   rom = 8'b0_1100_010;
      4'd11:   rom = 8'b1_1000_100;
      4'd12:   rom = 8'b0_0000_010;
      4'd13:   rom = 8'b0_0010_010;
      4'd14:   rom = 8'b0_0100_010;
      4'd15:   rom = 8'b1_0111_100;
      default: rom = 8'd0;
    endcase
  endfunction
  assign pri       = pending[0] ? 2'd0 : pending[1] ? 2'd1 : pending[2] ? 2'd2 : 2'd3;
  assign lower     = pending & ((4'd1 << cur) - 4'd1);
  assign addr_n    = start ? {pri, 2'b00} : addr + 4'd1;
  assign tick_done = cnt == TW'(TICK_DIV - 1);
  assign note_end  = tick_done && nt == {5'd0, dur} - 8'd1;
  assign gap_end   = tick_done && nt == 8'(GAP_TICKS - 1);
  assign busy      = state != IDLE;
`ifdef TONE_SEQ_MUTE_EN
  assign sound_en  = state == PLAY && !mute;
`else
  assign sound_en  = state == PLAY;
`endif
  // state register
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) state <= IDLE;
    else state <= nxt;
  // next state and grant pulse; preemption only at a note boundary
  always_comb begin
    nxt   = state;
    grant = 4'd0;
    case (state)
      IDLE: nxt = |pending ? LOAD : IDLE;
      LOAD: begin
        nxt   = PLAY;
        grant = start ? 4'd1 << pri : 4'd0;
      end
      PLAY: nxt = !note_end ? PLAY : |lower ? LOAD : last ? IDLE : GAP;
      GAP:  nxt = gap_end ? LOAD : GAP;
      default: nxt = IDLE;
    endcase
  end
  // pending requests, note registers and tick timing
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      pending <= 4'd0;
      start   <= 1'b0;
      cur     <= 2'd0;
      addr    <= 4'd0;
      tone    <= 4'd0;
      dur     <= 3'd0;
      last    <= 1'b0;
      cnt     <= '0;
      nt      <= 8'd0;
    end else begin
      pending <= (pending & ~grant) | req;
      if (nxt == LOAD) start <= state != GAP;
      if (state == LOAD) begin
        addr               <= addr_n;
        {last, tone, dur}  <= rom(addr_n);
        if (start) cur     <= pri;
      end
      if (nxt != state) begin
        cnt <= '0;
        nt  <= 8'd0;
      end else if (tick_done) begin
        cnt <= '0;
        nt  <= nt + 8'd1;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed checks of melody timing, priority, preemption, reset and optional mute
module tb_tone_sequencer;
  logic clk = 1'b0, resetN = 1'b0;
  logic [3:0] req = 4'd0, grant, tone;
  logic busy, sound_en;
`ifdef TONE_SEQ_MUTE_EN
  logic mute = 1'b0;
`endif
  int checks = 0, errors = 0;
  tone_sequencer #(.TICK_DIV(4), .GAP_TICKS(1)) dut (
    .clk(clk), .resetN(resetN), .req(req),
`ifdef TONE_SEQ_MUTE_EN
    .mute(mute),
`endif
    .grant(grant), .busy(busy), .tone(tone), .sound_en(sound_en));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
    req = 4'd0;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_grant(input logic [3:0] exp);
    int n = 0;
    while (grant == 4'd0 && n < 60) begin
      step();
      n++;
    end
    chk("grant", grant, exp);
    step();
    chk("grant_pulse", grant, 4'd0);
  endtask
  task automatic play_note(input logic [3:0] t, input int len, input int gap, input logic lst);
    int lw = 0, n = 0;
    while (!sound_en && lw < 60) begin
      step();
      lw++;
    end
    chk("gap_len", lw, gap);
    chk("note_tone", tone, t);
    while (sound_en && n < 60) begin
      n++;
      step();
    end
    chk("note_len", n, len);
    chk("busy_after_note", busy, !lst);
  endtask
  initial begin
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_tone", tone, 0);
    chk("rst_sound", sound_en, 0);
    resetN = 1'b1;
    step();
    req = 4'b1000;
    step();
    wait_grant(4'b1000);
    play_note(4'd0, 8, 0, 1'b0);
    play_note(4'd2, 8, 5, 1'b0);
    play_note(4'd4, 8, 5, 1'b0);
    play_note(4'd7, 16, 5, 1'b1);
    req = 4'b0101;
    step();
    wait_grant(4'b0001);
    play_note(4'd7, 4, 0, 1'b0);
    play_note(4'd4, 4, 5, 1'b1);
    wait_grant(4'b0100);
    play_note(4'd15, 8, 0, 1'b0);
    play_note(4'd13, 8, 5, 1'b0);
    play_note(4'd12, 8, 5, 1'b0);
    play_note(4'd8, 16, 5, 1'b1);
    req = 4'b1000;
    step();
    wait_grant(4'b1000);
    req = 4'b0010;
    play_note(4'd0, 8, 0, 1'b0);
    chk("preempt_grant", grant, 4'b0010);
    wait_grant(4'b0010);
    play_note(4'd2, 4, 0, 1'b0);
    play_note(4'd4, 4, 5, 1'b0);
    play_note(4'd6, 4, 5, 1'b0);
    play_note(4'd7, 12, 5, 1'b1);
    repeat (6) step();
    chk("no_resume_busy", busy, 0);
    req = 4'b0001;
    step();
    wait_grant(4'b0001);
    req = 4'b0100;
    play_note(4'd7, 4, 0, 1'b0);
    play_note(4'd4, 4, 5, 1'b1);
    wait_grant(4'b0100);
    req = 4'b1000;
    step();
    chk("pre_rst_tone", tone, 4'd15);
    chk("pre_rst_sound", sound_en, 1);
    resetN = 1'b0;
    #1;
    chk("async_grant", grant, 0);
    chk("async_busy", busy, 0);
    chk("async_tone", tone, 0);
    chk("async_sound", sound_en, 0);
    step();
    resetN = 1'b1;
    repeat (6) step();
    chk("pending_lost_busy", busy, 0);
    chk("pending_lost_grant", grant, 0);
`ifdef TONE_SEQ_MUTE_EN
    mute = 1'b1;
    req = 4'b0010;
    step();
    wait_grant(4'b0010);
    chk("mute_tone0", tone, 4'd2);
    chk("mute_sound0", sound_en, 0);
    repeat (9) step();
    chk("mute_tone1", tone, 4'd4);
    chk("mute_sound1", sound_en, 0);
    repeat (9) step();
    chk("mute_tone2", tone, 4'd6);
    repeat (9) step();
    chk("mute_tone3", tone, 4'd7);
    chk("mute_busy3", busy, 1);
    repeat (12) step();
    chk("mute_done", busy, 0);
    mute = 1'b0;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
